muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It consumes the same rs1/rs2 operand buses that feed the ALU, and its 32-bit result joins the ALU result at the writeback mux. It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with one bit per cycle. The control unit stalls the PC while `busy` is high.

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_unit.sv | 113 +++++++++++
 tb/tb_muldiv_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared RV32M op encoding, FSM states and iteration count for muldiv_unit
package muldiv_pkg;
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_e;
  localparam int MULDIV_ITERS = 32;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M mul/div, 1 bit/cycle; in clk,rst_n,start,op,a,b; out busy,done,result
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  muldiv_op_e      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(MULDIV_ITERS);
  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d, negr_q, negr_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              sa, sb, neg_a, neg_b, div_zero, div_ovf, fast, accept;
  logic [XLEN-1:0]   mag_a, mag_b, fast_res, quo, rem, fix_res;
  logic [XLEN:0]     mul_sum, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  always_comb begin
    sa       = op == MULH || op == MULHSU || op == DIV || op == REM;
    sb       = op == MULH || op == DIV || op == REM;
    neg_a    = sa & a[XLEN-1];
    neg_b    = sb & b[XLEN-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
    div_zero = op[2] && b == '0;
    div_ovf  = (op == DIV || op == REM) && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
    fast     = div_zero || div_ovf;
    fast_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
    accept   = start && (state_q == IDLE || state_q == DONE);
  end
  // multiply: acc = {partial product, remaining multiplier bits}; divide: acc = {remainder, dividend -> quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
    div_next = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    prod     = neg_q ? -acc_q : acc_q;
    quo      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem      = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_res  = op_q[2] ? (op_q[1] ? rem : quo)
                       : (op_q == MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    result_d = result_q;
    if (accept) begin
      op_d    = op;
      neg_d   = neg_a ^ neg_b;
      negr_d  = neg_a;
      cnt_d   = CW'(MULDIV_ITERS - 1);
      acc_d   = {{XLEN{1'b0}}, op[2] ? mag_a : mag_b};
      opnd_d  = op[2] ? mag_b : mag_a;
      state_d = fast ? DONE : CALC;
      if (fast) result_d = fast_res;
    end else begin
      case (state_q)
        CALC: begin
          acc_d   = op_q[2] ? div_next : mul_next;
          cnt_d   = cnt_q - 1'b1;
          state_d = cnt_q == '0 ? FIX : CALC;
        end
        FIX: begin
          result_d = fix_res;
          state_d  = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end
  assign busy   = state_q == CALC || state_q == FIX;
  assign done   = state_q == DONE;
  assign result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven scoreboard bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;
  typedef struct {
    muldiv_op_e  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          bsy;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  muldiv_op_e  op = MUL;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [31:0] sb_q[$];
  int          checks = 0;
  int          failures = 0;
  vec_t        tv[16];
  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic issue(input muldiv_op_e o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    sb_q.push_back(e);
  endtask
  task automatic wait_done(input string nm, input int lat, input int bsy, input int poke);
    int n;
    int bc;
    bit seen;
    logic [31:0] e;
    n = 0;
    bc = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      start = poke != 0 && n == poke;
      if (start) begin
        op = MULHU;
        a = 32'd7;
        b = 32'd9;
      end
      if (busy) bc++;
      if (done) seen = 1;
    end
    start = 1'b0;
    e = sb_q.pop_front();
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no done within %0d cycles", nm, n);
    end else begin
      chk({nm, "_result"}, result, e);
      chk({nm, "_latency"}, 32'(n), 32'(lat));
      chk({nm, "_busy_cycles"}, 32'(bc), 32'(bsy));
    end
  endtask
  initial begin
    tv[0]  = '{MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 33};
    tv[1]  = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, 33};
    tv[2]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 33};
    tv[3]  = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 33};
    tv[4]  = '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 33};
    tv[5]  = '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 33};
    tv[6]  = '{DIVU,   32'd100,      32'd7,        32'd14,       34, 33};
    tv[7]  = '{REMU,   32'd100,      32'd7,        32'd2,        34, 33};
    tv[8]  = '{DIVU,   32'h1234,     32'd0,        32'hFFFFFFFF, 1,  0};
    tv[9]  = '{REM,    32'h1234,     32'd0,        32'h1234,     1,  0};
    tv[10] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0};
    tv[11] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0};
    tv[12] = '{DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 33};
    tv[13] = '{REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34, 33};
    tv[14] = '{MULH,   32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 34, 33};
    tv[15] = '{DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        34, 33};
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      issue(tv[i].op, tv[i].a, tv[i].b, tv[i].exp);
      wait_done($sformatf("vec%0d", i), tv[i].lat, tv[i].bsy, 0);
      @(negedge clk);
    end
    issue(MUL, 32'd3, 32'd5, 32'd15);
    wait_done("ignored_start", 34, 33, 10);
    @(negedge clk);
    issue(MULHU, 32'hFFFFFFFF, 32'h2, 32'd1);
    wait_done("b2b_first", 34, 33, 0);
    issue(DIVU, 32'd100, 32'd7, 32'd14);
    wait_done("b2b_second", 34, 33, 0);
    issue(DIV, 32'd1000, 32'd3, 32'd333);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    void'(sb_q.pop_front());
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    chk("mid_reset_done", {31'd0, done}, 32'd0);
    chk("mid_reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(DIVU, 32'd9, 32'd3, 32'd3);
    wait_done("post_reset", 34, 33, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
